spike_event_encoder: RTL and testbench
======================================

# spike_event_encoder

Collects the per-neuron spike results produced by the neuron core during one timestep and serialises them as spike events for the on-chip router. Each event carries the index of one firing neuron. A double-buffered spike frame lets the next timestep's neuron evaluations be captured while the previous frame is being drained over a valid/ready handshake. It sits between the neuron-evaluation sequencer (which drives `neuron_block` once per neuron) and the spike router's input port.

## Interface
- `NUM_NEURONS`, default 256: neurons per core; must be a power of two, at most 256.
- `IDX_W`, default 8: width of a neuron index; equals log2(`NUM_NEURONS`).

Ports:
- `clk_i`, input, 1: core clock. One clock only.
- `rst_i`, input, 1: synchronous, active-high reset.
- `spike_valid_i`, input, 1: one neuron result is present this cycle.
- `neuron_idx_i`, input, `IDX_W`: index of the evaluated neuron.
- `spike_i`, input, 1: `spike_o` result of that neuron.
- `tick_i`, input, 1: end-of-timestep pulse; hands the captured frame to the emitter.
- `pkt_valid_o`, output, 1: a spike event is offered.
- `pkt_idx_o`, output, `IDX_W`: index of the firing neuron.
- `pkt_ready_i`, input, 1: the router accepts the event.
- `frame_done_o`, output, 1: one-cycle pulse after the last event of a frame, or after an empty frame.
- `busy_o`, output, 1: the emitter is not IDLE.
- `overflow_o`, output, 1: sticky flag; a tick arrived while busy. Cleared only by reset.

## Operation
- There are two `NUM_NEURONS`-bit banks: a capture bank and an emit bank.
- Capture:
  - When `spike_valid_i` is high, capture bit [`neuron_idx_i`] is written with `spike_i`. Writing 0 is allowed.
  - Indices ≥ `NUM_NEURONS` are ignored.
- `tick_i` while the emitter is IDLE:
  - Copy the capture bank into the emit bank, then clear the capture bank.
  - Pointer `p` is set to 0 and the state moves to SCAN.
  - If `spike_valid_i` is high in the same cycle as `tick_i`, that write belongs to the outgoing frame: it is merged into the emit copy and the capture bank still clears.
- `tick_i` while busy:
  - The tick is dropped and `overflow_o` is set.
  - The capture bank is untouched and keeps accumulating.
- Emitter FSM, with states IDLE, SCAN, EMIT and DONE:
  - **IDLE**: wait for `tick_i`.
  - **SCAN**: examine emit bit [`p`].
    - If the bit is set, register `pkt_idx_o` = `p`, set `pkt_valid_o`, and go to EMIT.
    - Else if `p` = `NUM_NEURONS`-1, go to DONE.
    - Else increment `p`.
  - **EMIT**: hold `pkt_valid_o` and `pkt_idx_o` stable until `pkt_ready_i`.
    - On handshake, clear `pkt_valid_o` and emit bit [`p`].
    - Then, if `p` = `NUM_NEURONS`-1, go to DONE; otherwise increment `p` and go to SCAN.
  - **DONE**: pulse `frame_done_o` and return to IDLE.
- Events leave in strictly ascending index order, with exactly one event per set bit.
- `pkt_ready_i` is ignored whenever `pkt_valid_o` is low.

## Timing
- Reset values:
  - All outputs are 0.
  - Both banks are cleared, state is IDLE and `p` = 0.
  - `overflow_o` is cleared.
- Reset mid-frame abandons the frame immediately. No `frame_done_o` is issued.
- Latency, with `tick_i` high in cycle c:
  - SCAN with `p` = 0 starts in cycle c+1.
  - If bit 0 is set, `pkt_valid_o` is high in cycle c+2.
- Empty frame: `frame_done_o` is high in cycle c+`NUM_NEURONS`+1.
- Throughput with `pkt_ready_i` held high: one event per 2 cycles (SCAN then EMIT), plus 1 cycle per zero bit.
- Capture writes take effect the cycle after `spike_valid_i`. Capture is never stalled.
- `busy_o` is high from cycle c+1 through the DONE cycle inclusive.
- A tick in the DONE cycle counts as busy: it is dropped and sets `overflow_o`.

## Structure
- Shared include `neuron_core_defs.vh` holds:
  - the `NUM_NEURONS`/`IDX_W` defaults, shared with the neuron sequencer;
  - the emitter state encodings, IDLE=0, SCAN=1, EMIT=2, DONE=3.
- Sub-module `spike_frame_buffer` holds the capture and emit banks, the indexed write, the swap/clear on tick, and the per-bit clear on handshake.
- The FSM and handshake live in the top module.

## Test plan
- Reset, then a tick with no spikes written → no `pkt_valid_o`; `frame_done_o` high exactly in cycle c+257; `busy_o` falls the cycle after.
- Write spikes to neurons 3, 200 and 255, with `pkt_ready_i`=1, then tick → events 3, 200, 255 in order, then one `frame_done_o` pulse; no other events.
- Same frame with `pkt_ready_i` low for 5 cycles on each event → `pkt_idx_o` stays constant while waiting; no event is lost or duplicated.
- `spike_valid_i` for neuron 7 in the same cycle as the tick, and neuron 9 one cycle later, then a second tick after `frame_done_o` → frame 1 emits 7 only; frame 2 emits 9 only.
- Tick while emitting frame 1 → `overflow_o` sticks at 1; frame 1 completes intact; the capture contents appear on the next accepted tick.
- Assert `rst_i` during EMIT of neuron 200 → all outputs 0 next cycle; no `frame_done_o`; a subsequent empty tick produces an empty frame.

Source files
------------

// File: rtl/spike_event_encoder_pkg.sv
// spike_event_encoder_pkg
//   Shared constants and types for the spike event encoder and the neuron
//   evaluation sequencer that feeds it.
//   - DEF_NUM_NEURONS / DEF_IDX_W : default core size and neuron index width
//   - emit_state_t                : emitter FSM encoding (IDLE=0, SCAN=1,
//                                   EMIT=2, DONE=3)
package spike_event_encoder_pkg;

    localparam int DEF_NUM_NEURONS = 256;
    localparam int DEF_IDX_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } emit_state_t;

endpackage

// File: rtl/spike_event_encoder_frame_buffer.sv
// spike_frame_buffer
//   Double-buffered spike frame. The capture bank collects per-neuron spike
//   results during a timestep; on swap it is copied (with any same-cycle
//   write merged in) into the emit bank and then cleared. The emitter clears
//   individual emit bits as their events are accepted.
//   Ports:
//     clk, rst   : core clock, synchronous active-high reset
//     wr_en      : write one capture bit this cycle
//     wr_idx     : neuron index of the write
//     wr_bit     : value written (0 or 1)
//     swap       : hand the capture bank to the emit bank, clear capture
//     clr_en     : clear emit bit clr_idx (event accepted)
//     clr_idx    : emit bit to clear
//     emit_bank  : current emit bank contents
module spike_frame_buffer
    import spike_event_encoder_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int IDX_W       = DEF_IDX_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic                   wr_bit,
    input  logic                   swap,
    input  logic                   clr_en,
    input  logic [IDX_W-1:0]       clr_idx,
    output logic [NUM_NEURONS-1:0] emit_bank
);

    logic [NUM_NEURONS-1:0] cap_bank;
    logic [NUM_NEURONS-1:0] cap_next;
    logic                   wr_ok;

    // Guards against an index wider than the bank if IDX_W is ever
    // configured larger than log2(NUM_NEURONS).
    assign wr_ok = wr_en && ({1'b0, wr_idx} < (IDX_W+1)'(NUM_NEURONS));

    // Capture bank with this cycle's write applied; a write coinciding with
    // swap belongs to the outgoing frame, so the merged value is what moves.
    always_comb begin
        cap_next = cap_bank;
        if (wr_ok)
            cap_next[wr_idx] = wr_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_bank  <= '0;
            emit_bank <= '0;
        end else if (swap) begin
            emit_bank <= cap_next;
            cap_bank  <= '0;
        end else begin
            cap_bank <= cap_next;
            if (clr_en)
                emit_bank[clr_idx] <= 1'b0;
        end
    end

endmodule

// File: rtl/spike_event_encoder.sv
// spike_event_encoder
//   Collects per-neuron spike results for one timestep and serialises the
//   firing neuron indices, in ascending order, to the spike router over a
//   valid/ready handshake. Capture of the next frame continues while the
//   previous frame drains.
//   Ports:
//     clk_i, rst_i   : core clock, synchronous active-high reset
//     spike_valid_i  : one neuron result present this cycle
//     neuron_idx_i   : index of that neuron
//     spike_i        : its spike result
//     tick_i         : end-of-timestep pulse, starts draining the frame
//     pkt_valid_o    : spike event offered
//     pkt_idx_o      : index of the firing neuron
//     pkt_ready_i    : router accepts the event
//     frame_done_o   : one-cycle pulse when a frame has fully drained
//     busy_o         : emitter is not idle
//     overflow_o     : sticky, a tick arrived while busy
module spike_event_encoder
    import spike_event_encoder_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int IDX_W       = DEF_IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             spike_valid_i,
    input  logic [IDX_W-1:0] neuron_idx_i,
    input  logic             spike_i,
    input  logic             tick_i,
    output logic             pkt_valid_o,
    output logic [IDX_W-1:0] pkt_idx_o,
    input  logic             pkt_ready_i,
    output logic             frame_done_o,
    output logic             busy_o,
    output logic             overflow_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    emit_state_t            state;
    logic [IDX_W-1:0]       p;
    logic [NUM_NEURONS-1:0] emit_bank;
    logic                   swap;
    logic                   accept;

    assign swap   = tick_i && (state == ST_IDLE);
    // pkt_valid_o is always high in EMIT, so ready alone completes the event.
    assign accept = (state == ST_EMIT) && pkt_ready_i;
    assign busy_o = (state != ST_IDLE);

    spike_frame_buffer #(
        .NUM_NEURONS (NUM_NEURONS),
        .IDX_W       (IDX_W)
    ) u_frame (
        .clk       (clk_i),
        .rst       (rst_i),
        .wr_en     (spike_valid_i),
        .wr_idx    (neuron_idx_i),
        .wr_bit    (spike_i),
        .swap      (swap),
        .clr_en    (accept),
        .clr_idx   (p),
        .emit_bank (emit_bank)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            p            <= '0;
            pkt_valid_o  <= 1'b0;
            pkt_idx_o    <= '0;
            frame_done_o <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            // DONE counts as busy, so a tick there is dropped too.
            if (tick_i && state != ST_IDLE)
                overflow_o <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (tick_i) begin
                        p     <= '0;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (emit_bank[p]) begin
                        pkt_idx_o   <= p;
                        pkt_valid_o <= 1'b1;
                        state       <= ST_EMIT;
                    end else if (p == LAST_IDX) begin
                        // frame_done_o is raised on entry so it is high
                        // during the DONE cycle itself.
                        frame_done_o <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        p <= p + 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (pkt_ready_i) begin
                        pkt_valid_o <= 1'b0;
                        if (p == LAST_IDX) begin
                            frame_done_o <= 1'b1;
                            state        <= ST_DONE;
                        end else begin
                            p     <= p + 1'b1;
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_event_encoder.sv
module tb_spike_event_encoder;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       spike_valid_i;
    logic [7:0] neuron_idx_i;
    logic       spike_i;
    logic       tick_i;
    logic       pkt_valid_o;
    logic [7:0] pkt_idx_o;
    logic       pkt_ready_i;
    logic       frame_done_o;
    logic       busy_o;
    logic       overflow_o;

    always #5 clk_i = ~clk_i;

    spike_event_encoder #(.NUM_NEURONS(256), .IDX_W(8)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .spike_valid_i (spike_valid_i),
        .neuron_idx_i  (neuron_idx_i),
        .spike_i       (spike_i),
        .tick_i        (tick_i),
        .pkt_valid_o   (pkt_valid_o),
        .pkt_idx_o     (pkt_idx_o),
        .pkt_ready_i   (pkt_ready_i),
        .frame_done_o  (frame_done_o),
        .busy_o        (busy_o),
        .overflow_o    (overflow_o)
    );

    int n_cmp = 0;
    int n_mis = 0;

    int got[$];
    int done_cyc;
    int first_n;

    typedef struct {
        int n_spk;
        int spk_idx[4];
        int spk_val[4];
        int stall;
        int n_exp;
        int exp_ev[4];
        int exp_first;
        int exp_done;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic write_spike(input int idx, input int val);
        spike_valid_i = 1'b1;
        neuron_idx_i  = 8'(idx);
        spike_i       = val[0];
        @(negedge clk_i);
        spike_valid_i = 1'b0;
    endtask

    // Called at a negedge in IDLE. Tick is raised for cycle c; iteration n
    // samples cycle c+n. late_idx >= 0 writes a spike in cycle c+1;
    // busy_tick_n > 0 raises tick again in cycle c+busy_tick_n.
    task automatic collect(input int stall, input int late_idx, input int busy_tick_n);
        int waitc;
        int held;
        bit seen;
        waitc    = 0;
        held     = 0;
        seen     = 0;
        done_cyc = -1;
        first_n  = -1;
        got.delete();
        pkt_ready_i = (stall == 0);
        tick_i = 1'b1;
        for (int n = 1; n <= 600; n++) begin
            @(negedge clk_i);
            tick_i = (n == busy_tick_n);
            if (n == 1) begin
                spike_valid_i = (late_idx >= 0);
                neuron_idx_i  = 8'(late_idx);
                spike_i       = 1'b1;
                chk("busy_rise", int'(busy_o), 1);
            end else begin
                spike_valid_i = 1'b0;
            end
            if (pkt_valid_o) begin
                if (first_n < 0) first_n = n;
                if (waitc == 0) held = int'(pkt_idx_o);
                else chk("idx_hold", int'(pkt_idx_o), held);
                if (waitc < stall) begin
                    pkt_ready_i = 1'b0;
                    waitc++;
                end else begin
                    pkt_ready_i = 1'b1;
                    got.push_back(int'(pkt_idx_o));
                    waitc = 0;
                end
            end else begin
                pkt_ready_i = (stall == 0);
            end
            if (frame_done_o) begin
                done_cyc = n;
                seen = 1;
                chk("busy_in_done", int'(busy_o), 1);
                break;
            end
        end
        if (!seen) chk("frame_done_timeout", 0, 1);
        @(negedge clk_i);
        tick_i      = 1'b0;
        pkt_ready_i = 1'b0;
        chk("busy_fall", int'(busy_o), 0);
        chk("done_single_pulse", int'(frame_done_o), 0);
    endtask

    initial begin
        rst_i         = 1'b1;
        spike_valid_i = 1'b0;
        neuron_idx_i  = '0;
        spike_i       = 1'b0;
        tick_i        = 1'b0;
        pkt_ready_i   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_pkt_valid", int'(pkt_valid_o), 0);
        chk("rst_pkt_idx", int'(pkt_idx_o), 0);
        chk("rst_frame_done", int'(frame_done_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_overflow", int'(overflow_o), 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Empty frame: done at c+257
        collect(0, -1, 0);
        chk("empty_events", got.size(), 0);
        chk("empty_done_cyc", done_cyc, 257);

        // Table-driven frames
        vecs[0].n_spk = 3; vecs[0].spk_idx = '{3, 200, 255, 0}; vecs[0].spk_val = '{1, 1, 1, 0};
        vecs[0].stall = 0; vecs[0].n_exp = 3; vecs[0].exp_ev = '{3, 200, 255, 0};
        vecs[0].exp_first = 5; vecs[0].exp_done = 260;
        vecs[1] = vecs[0];
        vecs[1].stall = 5; vecs[1].exp_done = 275;
        vecs[2].n_spk = 3; vecs[2].spk_idx = '{0, 1, 2, 0}; vecs[2].spk_val = '{1, 1, 1, 0};
        vecs[2].stall = 0; vecs[2].n_exp = 3; vecs[2].exp_ev = '{0, 1, 2, 0};
        vecs[2].exp_first = 2; vecs[2].exp_done = 260;
        vecs[3].n_spk = 3; vecs[3].spk_idx = '{10, 20, 10, 0}; vecs[3].spk_val = '{1, 1, 0, 0};
        vecs[3].stall = 0; vecs[3].n_exp = 1; vecs[3].exp_ev = '{20, 0, 0, 0};
        vecs[3].exp_first = 22; vecs[3].exp_done = 258;

        for (int v = 0; v < 4; v++) begin
            for (int s = 0; s < vecs[v].n_spk; s++)
                write_spike(vecs[v].spk_idx[s], vecs[v].spk_val[s]);
            collect(vecs[v].stall, -1, 0);
            chk($sformatf("v%0d_count", v), got.size(), vecs[v].n_exp);
            for (int e = 0; e < vecs[v].n_exp && e < got.size(); e++)
                chk($sformatf("v%0d_ev%0d", v, e), got[e], vecs[v].exp_ev[e]);
            chk($sformatf("v%0d_first", v), first_n, vecs[v].exp_first);
            chk($sformatf("v%0d_done", v), done_cyc, vecs[v].exp_done);
        end

        // Same-cycle write merges into outgoing frame; next-cycle write does not
        spike_valid_i = 1'b1; neuron_idx_i = 8'd7; spike_i = 1'b1;
        collect(0, 9, 0);
        chk("merge_f1_count", got.size(), 1);
        if (got.size() > 0) chk("merge_f1_ev", got[0], 7);
        collect(0, -1, 0);
        chk("merge_f2_count", got.size(), 1);
        if (got.size() > 0) chk("merge_f2_ev", got[0], 9);

        // Tick while busy
        write_spike(50, 1);
        chk("ovf_before", int'(overflow_o), 0);
        collect(0, 60, 4);
        chk("ovf_f1_count", got.size(), 1);
        if (got.size() > 0) chk("ovf_f1_ev", got[0], 50);
        chk("ovf_f1_done", done_cyc, 258);
        chk("ovf_set", int'(overflow_o), 1);
        collect(0, -1, 0);
        chk("ovf_f2_count", got.size(), 1);
        if (got.size() > 0) chk("ovf_f2_ev", got[0], 60);
        chk("ovf_sticky", int'(overflow_o), 1);

        // Reset during EMIT of neuron 200
        begin
            bit found;
            found = 0;
            write_spike(3, 1);
            write_spike(200, 1);
            tick_i = 1'b1;
            for (int n = 1; n <= 400; n++) begin
                @(negedge clk_i);
                tick_i = 1'b0;
                spike_valid_i = (n == 1);
                neuron_idx_i  = 8'd100;
                spike_i       = 1'b1;
                pkt_ready_i   = 1'b0;
                if (pkt_valid_o && pkt_idx_o == 8'd3) pkt_ready_i = 1'b1;
                if (pkt_valid_o && pkt_idx_o == 8'd200) begin
                    found = 1;
                    break;
                end
            end
            spike_valid_i = 1'b0;
            chk("rstmid_reached_200", int'(found), 1);
            rst_i = 1'b1;
            @(negedge clk_i);
            chk("rstmid_pkt_valid", int'(pkt_valid_o), 0);
            chk("rstmid_pkt_idx", int'(pkt_idx_o), 0);
            chk("rstmid_frame_done", int'(frame_done_o), 0);
            chk("rstmid_busy", int'(busy_o), 0);
            chk("rstmid_overflow", int'(overflow_o), 0);
            rst_i = 1'b0;
            for (int n = 0; n < 4; n++) begin
                @(negedge clk_i);
                chk("rstmid_no_done", int'(frame_done_o), 0);
            end
            collect(0, -1, 0);
            chk("rstmid_empty_events", got.size(), 0);
            chk("rstmid_empty_done", done_cyc, 257);
            chk("rstmid_ovf_clear", int'(overflow_o), 0);
        end

        // Tick in the DONE cycle is dropped and flags overflow
        collect(0, -1, 257);
        chk("donetick_events", got.size(), 0);
        chk("donetick_ovf", int'(overflow_o), 1);
        @(negedge clk_i);
        chk("donetick_idle", int'(busy_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
